// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller.
//   state_e         : controller FSM states
//   SIZE_*          : req_size encodings (SIZE_RSVD is rejected with rsp_err)
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2,
    WR_ISSUE   = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling for sub-word accesses (purely combinational).
//   size_i     : access size (SIZE_BYTE/HALF/WORD)
//   unsigned_i : 1 = zero-extend loads, 0 = sign-extend
//   off_i      : byte offset within the word (addr[1:0])
//   word_i     : 32-bit word read from memory
//   wdata_i    : right-aligned store data
//   load_o     : selected lane, extended to 32 bits
//   merge_o    : word_i with the store lane replaced by wdata_i
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [3:0][7:0] lanes;
  logic [3:0][7:0] merged;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  always_comb begin
    lanes  = word_i;
    byte_v = lanes[off_i];
    // halfword ignores addr[0]; only addr[1] picks the half
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SIZE_BYTE: load_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      SIZE_HALF: load_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      default:   load_o = word_i;
    endcase
  end

  always_comb begin
    merged = word_i;
    case (size_i)
      SIZE_BYTE: merged[off_i] = wdata_i[7:0];
      SIZE_HALF: begin
        merged[{off_i[1], 1'b0}] = wdata_i[7:0];
        merged[{off_i[1], 1'b1}] = wdata_i[15:8];
      end
      default:   merged = wdata_i;
    endcase
    merge_o = merged;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Core-to-SRAM access controller: byte/half/word loads and stores against a
// 32-bit memory with one-cycle registered read data. Sub-word stores are
// done as read-modify-write.
//   clk, rst (async, active-low)
//   req_*    : core request channel (valid/ready handshake)
//   rsp_*    : one-cycle response pulse with load data / error flag
//   mem_*    : registered memory interface (mem_dout is input)
// Optional: define MEM_ACCESS_MISALIGN_CHK_EN to reject misaligned half/word
// accesses with rsp_err instead of ignoring the low address bits.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-3:0] mem_ad,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  state_e            state_q, state_d;
  logic              we_q, we_d, uns_q, uns_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              mem_ce_q, mem_ce_d, mem_wre_q, mem_wre_d;
  logic [ADDR_W-3:0] mem_ad_q, mem_ad_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              req_bad;
  logic [31:0]       load_data, merge_data;

  always_comb begin
    req_bad = (req_size == SIZE_RSVD);
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    if (req_size == SIZE_HALF && req_addr[0])          req_bad = 1'b1;
    if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) req_bad = 1'b1;
`endif
  end

  mem_lane_align u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (off_q),
    .word_i     (mem_dout),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_wre_d   = 1'b0;
    mem_ad_d    = mem_ad_q;
    mem_din_d   = mem_din_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        uns_d   = req_unsigned;
        off_d   = req_addr[1:0];
        wdata_d = req_wdata;
        if (req_bad) begin
          // rejected without touching memory; answer next cycle
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (req_we && req_size == SIZE_WORD) begin
          state_d   = WR_ISSUE;
          mem_ad_d  = req_addr[ADDR_W-1:2];
          mem_din_d = req_wdata;
          mem_wre_d = 1'b1;
        end else begin
          // loads and sub-word stores both start with a read
          state_d  = RD_ISSUE;
          mem_ad_d = req_addr[ADDR_W-1:2];
        end
      end
      RD_ISSUE: state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        if (we_q) begin
          state_d   = WR_ISSUE;
          mem_din_d = merge_data;
          mem_wre_d = 1'b1;
        end else begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data;
        end
      end
      WR_ISSUE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // registered so mem_ce tracks the state the FSM is entering
    mem_ce_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_wre_q   <= 1'b0;
      mem_ad_q    <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_ce_q    <= mem_ce_d;
      mem_wre_q   <= mem_wre_d;
      mem_ad_q    <= mem_ad_d;
      mem_din_q   <= mem_din_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_ce    = mem_ce_q;
  assign mem_wre   = mem_wre_q;
  assign mem_ad    = mem_ad_q;
  assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-array reference model predicts
// each response at issue time; a monitor pops and compares on rsp_valid.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, mem_ce, mem_wre;
  logic [31:0]   rsp_rdata, mem_din, mem_dout;
  logic [AW-3:0] mem_ad;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_ce(mem_ce),
    .mem_wre(mem_wre), .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // memory with registered read; poke port preloads contents from the bench
  logic [31:0] mem_w [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  always @(posedge clk) begin
    if (poke_en) mem_w[poke_idx] <= poke_val;
    else if (mem_ce) begin
      if (mem_wre) mem_w[mem_ad] <= mem_din;
      else         mem_dout <= mem_w[mem_ad];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int h; int lat; } exp_t;
  exp_t q[$];
  logic [7:0] ref_b [0:1023];
  int n_cmp = 0, n_bad = 0, wre_cnt = 0, wre_exp = 0;
  logic prev_wre = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [AW-1:0] a);
    logic e = (sz == 2'd3);
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    if (sz == 2'd1 && a[0]) e = 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  // naturally aligned container of n bytes, assembled little-endian
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [AW-1:0] a);
    int n = nbytes(sz);
    int base = int'(a) & ~(n - 1);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(ref_b[base + i]) << (8 * i);
    if (!uns && n < 4 && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx[7:0]; poke_val = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[4*idx+i] = v[8*i +: 8];
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [AW-1:0] a, input logic [31:0] wd);
    exp_t e;
    int w = 0;
    int n, base;
    @(negedge clk);
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin chk("ready_timeout", {31'b0, req_ready}, 32'd1); return; end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    e.err = ref_err(sz, a);
    e.rdata = (e.err || we) ? 32'h0 : ref_load(sz, uns, a);
    e.lat = e.err ? 1 : !we ? 3 : (sz == 2'd2) ? 2 : 4;
    e.h = cyc + 1;
    if (!e.err && we) begin
      n = nbytes(sz);
      base = int'(a) & ~(n - 1);
      for (int i = 0; i < n; i++) ref_b[base + i] = wd[8*i +: 8];
      wre_exp++;
    end
    q.push_back(e);
    @(posedge clk); #1;
    // scramble request fields while busy; they must be ignored
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 100) begin @(negedge clk); w++; end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      chk("ce_vs_busy", {31'b0, mem_ce}, {31'b0, !req_ready});
      chk("wre_width", {31'b0, mem_wre & prev_wre}, 32'd0);
      if (mem_wre) wre_cnt++;
      prev_wre = mem_wre;
      if (rsp_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
        else begin
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("rsp_latency", 32'(cyc - e.h + 1), 32'(e.lat));
        end
      end
    end else prev_wre = 1'b0;
  end

  initial begin
    int w0;
    logic [AW-1:0] a;
    #3 rst = 1'b0;
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_ce", {31'b0, mem_ce}, 32'd0);
    chk("rst_mem_wre", {31'b0, mem_wre}, 32'd0);
    chk("rst_mem_ad", 32'(mem_ad), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    poke(10, 32'h0000_0006);
    poke(11, 32'h0000_80F0);
    @(negedge clk); rst = 1'b1;

    // directed cases
    do_req(1'b0, SIZE_WORD, 1'b0, 10'd40, 32'h0);
    do_req(1'b0, SIZE_HALF, 1'b0, 10'd44, 32'h0);
    do_req(1'b0, SIZE_BYTE, 1'b1, 10'd45, 32'h0);
    drain();
    poke(11, 32'h1122_3344);
    w0 = wre_cnt;
    do_req(1'b1, SIZE_BYTE, 1'b0, 10'd46, 32'h0000_00AB);
    drain();
    chk("rmw_word11", mem_w[11], 32'h11AB_3344);
    chk("rmw_wre_pulses", 32'(wre_cnt - w0), 32'd1);
    do_req(1'b1, SIZE_WORD, 1'b0, 10'd8, 32'hDEAD_BEEF);
    do_req(1'b0, SIZE_WORD, 1'b0, 10'd8, 32'h0);
    w0 = wre_cnt;
    do_req(1'b1, SIZE_RSVD, 1'b0, 10'd12, 32'h1234_5678);
    do_req(1'b0, SIZE_RSVD, 1'b1, 10'd16, 32'h0);
    drain();
    chk("rsvd_no_wre", 32'(wre_cnt - w0), 32'd0);
    do_req(1'b0, SIZE_WORD, 1'b0, 10'd41, 32'h0);
    do_req(1'b0, SIZE_HALF, 1'b1, 10'd47, 32'h0);
    do_req(1'b1, SIZE_HALF, 1'b0, 10'd51, 32'hCAFE_9876);
    do_req(1'b0, SIZE_WORD, 1'b0, 10'd48, 32'h0);
    drain();

    // reset in RD_CAPTURE of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_BYTE; req_unsigned = 1'b0;
    req_addr = 10'd46; req_wdata = 32'h0000_0055;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    w0 = wre_cnt;
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_mem_wre", {31'b0, mem_wre}, 32'd0);
    chk("midrst_mem_ce", {31'b0, mem_ce}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_wre", 32'(wre_cnt - w0), 32'd0);
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_word11", mem_w[11], ref_word(11));

    // random traffic
    for (int k = 0; k < 300; k++) begin
      a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom);
      do_req(1'($urandom), ($urandom_range(0, 9) == 0) ? SIZE_RSVD : 2'($urandom_range(0, 2)),
             1'($urandom), a, $urandom);
    end
    drain();
    chk("total_wre_pulses", 32'(wre_cnt), 32'(wre_exp));
    for (int i = 0; i < 256; i++) chk("final_mem", mem_w[i], ref_word(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, byte-address width of the core-side request; memory word index = req_addr[ADDR_W-1:2].
REQ-002 SHALL have ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  core request present.
- req_ready  output  1  controller accepts a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 reserved.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, extended; 0 for stores.
- rsp_err  output  1  access rejected; valid with rsp_valid.
- mem_ce  output  1  memory chip enable.
- mem_wre  output  1  memory write enable.
- mem_ad  output  ADDR_W-2  memory word index.
- mem_din  output  32  memory write data.
- mem_dout  input  32  memory read data; registered in the memory, valid one clock after mem_ad is presented with mem_wre=0.

Function
REQ-003 SHALL implement states IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE.
REQ-004 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid&&req_ready at a posedge.
REQ-005 SHALL register all mem_* outputs; mem_wre SHALL be 1 for exactly one cycle per store and 0 at all other times.
REQ-006 SHALL drive mem_ce=1 in every non-IDLE state and 0 in IDLE.
REQ-007 Load: IDLE -> RD_ISSUE (mem_ad presented) -> RD_CAPTURE (mem_dout sampled) -> IDLE; rsp_valid SHALL rise in the cycle after RD_CAPTURE, i.e. 3 edges after the accepting edge.
REQ-008 Load SHALL select lane by req_addr[1:0] (byte) or req_addr[1] (half), little-endian, then extend per req_unsigned.
REQ-009 Word store: IDLE -> WR_ISSUE with mem_din=req_wdata -> IDLE; rsp_valid SHALL pulse in the cycle after WR_ISSUE.
REQ-010 Byte/half store SHALL be read-modify-write: RD_ISSUE -> RD_CAPTURE -> merge lane into mem_dout -> WR_ISSUE -> IDLE; untouched lanes SHALL be preserved.
REQ-011 Request fields SHALL be latched at handshake; changes on req_* while busy SHALL have no effect.
REQ-012 req_size=11 SHALL produce rsp_err=1 with no memory access, rsp_valid in the cycle after handshake.
REQ-013 rsp_valid and req_ready MAY be high in the same cycle; a new request accepted then SHALL proceed normally.

Reset
REQ-014 On rst low, asynchronously: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_ce=0, mem_wre=0, mem_ad=0, mem_din=0.
REQ-015 Reset mid-operation SHALL abandon the access without a response; a write not yet sampled by the memory is lost.

Configuration
REQ-016 With MEM_ACCESS_MISALIGN_CHK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL return rsp_err=1, no memory access, same timing as REQ-012.
REQ-017 Without it: misaligned low address bits SHALL be ignored (halfword uses addr[1], word ignores addr[1:0]) and rsp_err arises only from REQ-012.

Structure
REQ-018 A shared package SHALL hold the state enumeration and req_size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
REQ-019 Lane extract/extend and merge logic SHALL form one sub-module, mem_lane_align.

Verification
REQ-020 Memory model word 10 = 0x00000006; load word addr 40 -> rsp_rdata=0x00000006, rsp_valid 3 edges after handshake.
REQ-021 Word 11 = 0x000080F0; signed half load addr 44 -> 0xFFFF80F0; unsigned byte load addr 45 -> 0x00000080.
REQ-022 Word 11 = 0x11223344; byte store 0xAB to addr 46 -> word 11 = 0x11AB3344, exactly one mem_wre pulse, ack 4 edges after handshake.
REQ-023 Word store 0xDEADBEEF to addr 8 then load addr 8 back-to-back on ack cycle -> 0xDEADBEEF.
REQ-024 req_size=11 -> rsp_err=1, mem_wre never 1; with MEM_ACCESS_MISALIGN_CHK_EN, word load addr 41 -> rsp_err=1.
REQ-025 Assert rst low in RD_CAPTURE of a byte store -> no mem_wre pulse, no rsp_valid, req_ready=1 after release.
